// File: rtl/hashcore_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hashcore_pkg
// Brief   : Shared types and default constants for the nonce sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package hashcore_pkg;

  // Sequencer state: waiting for first load, hashing, range exhausted
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_PERIOD      = 19;
  localparam int DEFAULT_PREFIX_BITS = 5;
  localparam int NONCE_W             = 32;

endpackage
`default_nettype wire

// File: rtl/hashcore_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module  : gn_fifo
// Brief   : Synchronous golden-nonce FIFO, DEPTH x 32, with occupancy level.
//           A push into a full FIFO is accepted when a pop happens alongside.
// Revision: 1.0 - initial release
// ============================================================================
module gn_fifo
  import hashcore_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [NONCE_W-1:0]     push_data,
  input  logic                   pop,
  output logic [NONCE_W-1:0]     head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level_q, level_d;
  logic [NONCE_W-1:0]   mem_q [DEPTH];
  logic                 do_push, do_pop;

  // Handshake qualification and next pointer/level computation
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_FULL);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer and occupancy registers; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/hashcore_seq.sv
`default_nettype none
// ============================================================================
// Module  : hashcore_seq
// Brief   : Nonce sequencer for one external BLAKE midstate core, with a
//           golden-nonce FIFO and optional stop-at-wrap range exhaustion.
// Revision: 1.0 - initial release
// ============================================================================
module hashcore_seq
  import hashcore_pkg::*;
#(
  parameter int PERIOD       = DEFAULT_PERIOD,
  parameter int PREFIX_BITS  = DEFAULT_PREFIX_BITS,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_AT_WRAP = 0
) (
  input  logic                                    hash_clk,
  input  logic                                    reset,
  input  logic                                    shift,
  input  logic [NONCE_W-1:0]                      init_nonce,
  input  logic [((PREFIX_BITS > 0) ? PREFIX_BITS : 1)-1:0] core_id,
  input  logic                                    gn_match,
  output logic                                    start,
  output logic [NONCE_W-1:0]                      nonce,
  output logic [NONCE_W-1:0]                      gn_data,
  output logic                                    gn_valid,
  input  logic                                    gn_ready,
  output logic [$clog2(FIFO_DEPTH):0]             gn_level,
  output logic                                    gn_overflow,
  output logic                                    exhausted,
  output logic                                    busy
);

  localparam int              CNT_W   = NONCE_W - PREFIX_BITS;
  localparam int              PH_W    = $clog2(PERIOD + 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD);
  localparam bit              STOP    = (STOP_AT_WRAP != 0);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              shift_d_q, shift_d_d;
  logic              start_q, start_d;
  logic              exhausted_q, exhausted_d;
  logic              overflow_q, overflow_d;
  logic              load;
  logic              push_req;
  logic              fifo_full, fifo_empty;
  logic              unused_inputs;

  // Upper init_nonce bits are replaced by the prefix; core_id is idle with no prefix
  assign unused_inputs = ^{init_nonce, core_id};

  assign load = shift_d_q & ~shift;

  // Next-state logic: load from any state, phase stepping, sampling and wrap
  always_comb begin
    shift_d_d   = shift;
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    exhausted_d = exhausted_q;
    overflow_d  = overflow_q;
    push_req    = 1'b0;
    if (load) begin
      cnt_d       = init_nonce[CNT_W-1:0];
      state_d     = ST_RUN;
      phase_d     = '0;
      exhausted_d = 1'b0;
      overflow_d  = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (shift) begin
        // Loader is rewriting the core: abandon the in-flight hash
        phase_d = '0;
      end else begin
        start_d = (phase_q == PH_ONE);
        if (phase_q == PH_LAST) begin
          push_req = gn_match;
          if (push_req && fifo_full && !gn_ready) begin
            overflow_d = 1'b1;
          end
          if (STOP && (&cnt_q)) begin
            state_d     = ST_DONE;
            exhausted_d = 1'b1;
            phase_d     = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = PH_ONE;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
    end
  end

  // Sequencer state registers with synchronous reset
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      cnt_q       <= '0;
      shift_d_q   <= 1'b0;
      start_q     <= 1'b0;
      exhausted_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      shift_d_q   <= shift_d_d;
      start_q     <= start_d;
      exhausted_q <= exhausted_d;
      overflow_q  <= overflow_d;
    end
  end

  generate
    if (PREFIX_BITS > 0) begin : g_prefix
      assign nonce = {core_id, cnt_q};
    end else begin : g_no_prefix
      assign nonce = cnt_q;
    end
  endgenerate

  gn_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_gn_fifo (
    .clk       (hash_clk),
    .rst       (reset),
    .push      (push_req),
    .push_data (nonce),
    .pop       (gn_ready),
    .head      (gn_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (gn_level)
  );

  assign gn_valid    = ~fifo_empty;
  assign gn_overflow = overflow_q;
  assign exhausted   = exhausted_q;
  assign start       = start_q;
  assign busy        = (state_q == ST_RUN);

endmodule
`default_nettype wire
